// File: rtl/ddr4_cmd_issue_q.sv
// ---------------------------------------------------------------------------
// ddr4_cmd_issue_q
//
// DDR4 command issue stage. Decoded controller commands are buffered in an
// in-order FIFO and encoded onto registered DDR4 command/address pins
// following the JEDEC truth table. A pending refresh is injected ahead of
// the queue whenever the queue head is not held off by tCCD spacing.
// Idle pins carry DES.
//
// Optional feature: define DDR4_CA_PARITY_EN to add the PAR output (even
// parity over the command/address pins, registered with them, 0 on DES).
//
// Ports
//   CK_t            clock, all logic on the rising edge
//   reset           synchronous, active-high
//   in_valid/ready  command push handshake (in_ready = FIFO not full)
//   in_cmd          command code (0 NOP .. 11 ZQCL, 12-15 issued as NOP)
//   in_rank, in_bg, in_ba, in_row, in_col, in_bc_n   command fields
//   tccd            CAS-to-CAS spacing in cycles (values below 4 act as 4)
//   ref_req         refresh request pulse, ref_rank = refresh target
//   ref_ack         one-cycle pulse while the injected REF is on the pins
//   cs_n .. A9_A0   registered DDR4 command/address pins
//   issued_valid    pins carry a non-DES command this cycle
//   issued_cmd      code currently on the pins
//   count           FIFO occupancy
//   PAR             C/A parity (only with DDR4_CA_PARITY_EN)
// ---------------------------------------------------------------------------
module ddr4_cmd_issue_q #(
    parameter int DEPTH     = 8,
    parameter int NUM_RANKS = 1,
    parameter int ROW_W     = 14,
    parameter int COL_W     = 10,
    parameter int BG_W      = 2,
    parameter int BA_W      = 2,
    localparam int RANK_W   = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                 CK_t,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_cmd,
    input  logic [RANK_W-1:0]    in_rank,
    input  logic [BG_W-1:0]      in_bg,
    input  logic [BA_W-1:0]      in_ba,
    input  logic [ROW_W-1:0]     in_row,
    input  logic [COL_W-1:0]     in_col,
    input  logic                 in_bc_n,
    input  logic [3:0]           tccd,
    input  logic                 ref_req,
    input  logic [RANK_W-1:0]    ref_rank,
    output logic                 ref_ack,
    output logic [NUM_RANKS-1:0] cs_n,
    output logic                 act_n,
    output logic                 RAS_n_A16,
    output logic                 CAS_n_A15,
    output logic                 WE_n_A14,
    output logic                 A17,
    output logic                 A13,
    output logic                 A12_BC_n,
    output logic                 A11,
    output logic                 A10_AP,
    output logic [BG_W-1:0]      bg_addr,
    output logic [BA_W-1:0]      ba_addr,
    output logic [9:0]           A9_A0,
    output logic                 issued_valid,
    output logic [3:0]           issued_cmd,
    output logic [CNT_W-1:0]     count
`ifdef DDR4_CA_PARITY_EN
    ,
    output logic                 PAR
`endif
);

    localparam logic [3:0] CMD_NOP  = 4'd0;
    localparam logic [3:0] CMD_DES  = 4'd1;
    localparam logic [3:0] CMD_ACT  = 4'd2;
    localparam logic [3:0] CMD_RD   = 4'd3;
    localparam logic [3:0] CMD_WR   = 4'd4;
    localparam logic [3:0] CMD_RDA  = 4'd5;
    localparam logic [3:0] CMD_WRA  = 4'd6;
    localparam logic [3:0] CMD_PRE  = 4'd7;
    localparam logic [3:0] CMD_PREA = 4'd8;
    localparam logic [3:0] CMD_REF  = 4'd9;
    localparam logic [3:0] CMD_MRS  = 4'd10;
    localparam logic [3:0] CMD_ZQCL = 4'd11;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [RANK_W-1:0] rank;
        logic [BG_W-1:0]   bg;
        logic [BA_W-1:0]   ba;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic              bc_n;
    } entry_t;

    typedef struct packed {
        logic [NUM_RANKS-1:0] cs_n;
        logic                 act_n;
        logic                 ras;
        logic                 cas;
        logic                 we;
        logic                 a17;
        logic                 a13;
        logic                 a12;
        logic                 a11;
        logic                 a10;
        logic [BG_W-1:0]      bg;
        logic [BA_W-1:0]      ba;
        logic [9:0]           a9_0;
        logic                 valid;
        logic [3:0]           cmd;
    } pins_t;

    // Deselect: every pin high, nothing issued.
    function automatic pins_t des_pins();
        pins_t p;
        p       = '1;
        p.valid = 1'b0;
        p.cmd   = CMD_DES;
        return p;
    endfunction

    function automatic logic [NUM_RANKS-1:0] rank_cs(input logic [RANK_W-1:0] r);
        logic [NUM_RANKS-1:0] cs;
        cs = '1;
        for (int i = 0; i < NUM_RANKS; i++) begin
            cs[i] = (r != RANK_W'(i));
        end
        return cs;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        tccd_cnt_q, tccd_cnt_d;
    logic              ref_pend_q, ref_pend_d;
    logic [RANK_W-1:0] ref_rank_q, ref_rank_d;
    logic              ref_ack_q, ref_ack_d;
    pins_t             pins_q, pins_d;
`ifdef DDR4_CA_PARITY_EN
    logic              par_q, par_d;
`endif

    entry_t     in_entry;
    entry_t     head;
    logic       empty, full, push, pop;
    logic       head_is_cas, head_blocked, issue_ref;
    logic [3:0] tccd_eff;
    logic [17:0] row_ox;
    logic [9:0]  col_ext;
    logic        mrs_a17;

    assign in_entry = '{cmd: in_cmd, rank: in_rank, bg: in_bg, ba: in_ba,
                        row: in_row, col: in_col, bc_n: in_bc_n};
    assign head     = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign push     = in_valid && !full;

    assign head_is_cas  = !empty && (head.cmd inside {CMD_RD, CMD_WR, CMD_RDA, CMD_WRA});
    assign head_blocked = head_is_cas && (tccd_cnt_q != 4'd0);
    // Refresh outranks the queue, but never jumps past a head that is only
    // waiting for tCCD; that keeps REF adjacent to the CAS it delays.
    assign issue_ref    = ref_pend_q && !head_blocked;
    assign pop          = !issue_ref && !empty && !head_blocked;
    assign tccd_eff     = (tccd < 4'd4) ? 4'd4 : tccd;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        ref_ack_d  = issue_ref;
        // A request arriving while one is pending merges into it; the most
        // recent target rank is kept.
        ref_pend_d = ref_req || (ref_pend_q && !issue_ref);
        ref_rank_d = ref_req ? ref_rank : ref_rank_q;

        // Loading tccd-1 makes the next CAS eligible exactly tccd cycles on.
        if (pop && head_is_cas) begin
            tccd_cnt_d = tccd_eff - 4'd1;
        end else if (tccd_cnt_q != 4'd0) begin
            tccd_cnt_d = tccd_cnt_q - 4'd1;
        end else begin
            tccd_cnt_d = tccd_cnt_q;
        end
    end

    // Row padded with ones above ROW_W (ACT drives absent high bits as 1);
    // MRS opcodes are zero-extended instead, which only affects A17.
    always_comb begin
        row_ox                 = '1;
        row_ox[ROW_W-1:0]      = head.row;
        col_ext                = '0;
        col_ext[COL_W-1:0]     = head.col;
        mrs_a17                = (ROW_W > 17) ? row_ox[17] : 1'b0;
    end

    always_comb begin
        pins_d = des_pins();
        if (issue_ref) begin
            pins_d.cs_n  = rank_cs(ref_rank_q);
            pins_d.valid = 1'b1;
            pins_d.cmd   = CMD_REF;
            pins_d.ras   = 1'b0;
            pins_d.cas   = 1'b0;
        end else if (pop) begin
            pins_d.cs_n  = rank_cs(head.rank);
            pins_d.valid = 1'b1;
            pins_d.cmd   = head.cmd;
            case (head.cmd)
                CMD_NOP: ;
                CMD_DES: pins_d = des_pins();
                CMD_ACT: begin
                    pins_d.act_n = 1'b0;
                    pins_d.ras   = row_ox[16];
                    pins_d.cas   = row_ox[15];
                    pins_d.we    = row_ox[14];
                    pins_d.a17   = row_ox[17];
                    {pins_d.a13, pins_d.a12, pins_d.a11, pins_d.a10, pins_d.a9_0} = row_ox[13:0];
                    pins_d.bg    = head.bg;
                    pins_d.ba    = head.ba;
                end
                CMD_RD, CMD_WR, CMD_RDA, CMD_WRA: begin
                    pins_d.cas   = 1'b0;
                    pins_d.we    = !(head.cmd == CMD_WR || head.cmd == CMD_WRA);
                    pins_d.a12   = head.bc_n;
                    pins_d.a10   = (head.cmd == CMD_RDA || head.cmd == CMD_WRA);
                    pins_d.a9_0  = col_ext;
                    pins_d.bg    = head.bg;
                    pins_d.ba    = head.ba;
                end
                CMD_PRE: begin
                    pins_d.ras   = 1'b0;
                    pins_d.we    = 1'b0;
                    pins_d.a10   = 1'b0;
                    pins_d.bg    = head.bg;
                    pins_d.ba    = head.ba;
                end
                CMD_PREA: begin
                    pins_d.ras   = 1'b0;
                    pins_d.we    = 1'b0;
                    pins_d.a10   = 1'b1;
                end
                CMD_REF: begin
                    pins_d.ras   = 1'b0;
                    pins_d.cas   = 1'b0;
                end
                CMD_MRS: begin
                    pins_d.ras   = 1'b0;
                    pins_d.cas   = 1'b0;
                    pins_d.we    = 1'b0;
                    pins_d.bg    = head.bg;
                    pins_d.ba    = head.ba;
                    pins_d.a17   = mrs_a17;
                    {pins_d.a13, pins_d.a12, pins_d.a11, pins_d.a10, pins_d.a9_0} = row_ox[13:0];
                end
                CMD_ZQCL: begin
                    pins_d.we    = 1'b0;
                    pins_d.a10   = 1'b1;
                end
                // Illegal codes leave the queue as a plain NOP.
                default: pins_d.cmd = CMD_NOP;
            endcase
        end
    end

`ifdef DDR4_CA_PARITY_EN
    always_comb begin
        par_d = pins_d.valid ? ^{pins_d.act_n, pins_d.ras, pins_d.cas, pins_d.we,
                                 pins_d.bg, pins_d.ba, pins_d.a17, pins_d.a13,
                                 pins_d.a12, pins_d.a11, pins_d.a10, pins_d.a9_0}
                             : 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CK_t) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tccd_cnt_q <= 4'd0;
            ref_pend_q <= 1'b0;
            ref_rank_q <= '0;
            ref_ack_q  <= 1'b0;
            pins_q     <= des_pins();
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tccd_cnt_q <= tccd_cnt_d;
            ref_pend_q <= ref_pend_d;
            ref_rank_q <= ref_rank_d;
            ref_ack_q  <= ref_ack_d;
            pins_q     <= pins_d;
        end
    end

`ifdef DDR4_CA_PARITY_EN
    always_ff @(posedge CK_t) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= par_d;
    end
    assign PAR = par_q;
`endif

    // NOTE: the storage array has no reset; occupancy and pointers decide
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge CK_t) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready     = !full;
    assign count        = count_q;
    assign ref_ack      = ref_ack_q;
    assign cs_n         = pins_q.cs_n;
    assign act_n        = pins_q.act_n;
    assign RAS_n_A16    = pins_q.ras;
    assign CAS_n_A15    = pins_q.cas;
    assign WE_n_A14     = pins_q.we;
    assign A17          = pins_q.a17;
    assign A13          = pins_q.a13;
    assign A12_BC_n     = pins_q.a12;
    assign A11          = pins_q.a11;
    assign A10_AP       = pins_q.a10;
    assign bg_addr      = pins_q.bg;
    assign ba_addr      = pins_q.ba;
    assign A9_A0        = pins_q.a9_0;
    assign issued_valid = pins_q.valid;
    assign issued_cmd   = pins_q.cmd;

endmodule

// File: tb/tb_ddr4_cmd_issue_q.sv
// ---------------------------------------------------------------------------
// tb_ddr4_cmd_issue_q
//
// Directed bench for ddr4_cmd_issue_q (two ranks, other parameters default).
// Outputs are sampled 1 time unit after each rising edge; expected values
// are hand-derived from the command truth table and the tCCD timing.
// ---------------------------------------------------------------------------
module tb_ddr4_cmd_issue_q;

    logic        CK_t = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cmd;
    logic [0:0]  in_rank;
    logic [1:0]  in_bg;
    logic [1:0]  in_ba;
    logic [13:0] in_row;
    logic [9:0]  in_col;
    logic        in_bc_n;
    logic [3:0]  tccd;
    logic        ref_req;
    logic [0:0]  ref_rank;
    logic        ref_ack;
    logic [1:0]  cs_n;
    logic        act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    logic        A17, A13, A12_BC_n, A11, A10_AP;
    logic [1:0]  bg_addr, ba_addr;
    logic [9:0]  A9_A0;
    logic        issued_valid;
    logic [3:0]  issued_cmd;
    logic [3:0]  count;
`ifdef DDR4_CA_PARITY_EN
    logic        par;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 CK_t = ~CK_t;

    ddr4_cmd_issue_q #(.NUM_RANKS(2)) dut (
        .CK_t(CK_t), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
        .in_rank(in_rank), .in_bg(in_bg), .in_ba(in_ba), .in_row(in_row),
        .in_col(in_col), .in_bc_n(in_bc_n), .tccd(tccd),
        .ref_req(ref_req), .ref_rank(ref_rank), .ref_ack(ref_ack),
        .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16),
        .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14), .A17(A17), .A13(A13),
        .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP),
        .bg_addr(bg_addr), .ba_addr(ba_addr), .A9_A0(A9_A0),
        .issued_valid(issued_valid), .issued_cmd(issued_cmd), .count(count)
`ifdef DDR4_CA_PARITY_EN
        , .PAR(par)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK_t);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [0:0] r, input logic [1:0] g,
                         input logic [1:0] b, input logic [13:0] row, input logic [9:0] col,
                         input logic bc);
        in_valid = 1'b1;
        in_cmd   = c;
        in_rank  = r;
        in_bg    = g;
        in_ba    = b;
        in_row   = row;
        in_col   = col;
        in_bc_n  = bc;
    endtask

    // Pin bundle: {cs_n, act_n/RAS/CAS/WE, A17/A13/A12/A11/A10, A9_A0, bg, ba}
    function automatic logic [31:0] pins_vec();
        return {7'b0, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
                A17, A13, A12_BC_n, A11, A10_AP, A9_A0, bg_addr, ba_addr};
    endfunction

    function automatic logic [31:0] exp_vec(input logic [1:0] cs, input logic [3:0] ctrl,
                                            input logic [4:0] hi, input logic [9:0] a,
                                            input logic [1:0] g, input logic [1:0] b);
        return {7'b0, cs, ctrl, hi, a, g, b};
    endfunction

    task automatic check_des(input string tag);
        check({tag, "_pins"}, pins_vec(), exp_vec(2'b11, 4'hF, 5'h1F, 10'h3FF, 2'h3, 2'h3));
        check({tag, "_cmd"}, {issued_valid, issued_cmd}, 5'b0_0001);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_cmd = 4'd0; in_rank = 1'b0;
        in_bg = 2'd0; in_ba = 2'd0; in_row = 14'd0; in_col = 10'd0; in_bc_n = 1'b1;
        tccd = 4'd6; ref_req = 1'b0; ref_rank = 1'b0;

        // Reset, then idle
        repeat (3) tick();
        check("rst_count", count, 0);
        check("rst_ready", in_ready, 1);
        check("rst_ack", ref_ack, 0);
        check_des("rst");
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_cs", cs_n, 2'b11);
            check("idle_valid", issued_valid, 0);
            check("idle_count", count, 0);
            check("idle_ready", in_ready, 1);
        end

        // Single ACT: accepted on edge k, on pins after k+1, then DES
        drive(4'd2, 1'b0, 2'd1, 2'd2, 14'h1ABC, 10'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("act_count1", count, 1);
        check("act_not_yet", issued_valid, 0);
        tick();
        check("act_pins", pins_vec(), exp_vec(2'b10, 4'b0111, 5'b10110, 10'h2BC, 2'd1, 2'd2));
        check("act_cmd", {issued_valid, issued_cmd}, 5'b1_0010);
        check("act_count0", count, 0);
        tick();
        check_des("act_after");

        // RD, RD, WR back-to-back with tccd=6
        drive(4'd3, 1'b0, 2'd0, 2'd1, 14'd0, 10'h155, 1'b1);
        tick();
        check("cas_count_e0", count, 1);
        drive(4'd3, 1'b1, 2'd2, 2'd3, 14'd0, 10'h0AA, 1'b0);
        tick();
        check("rd1_pins", pins_vec(), exp_vec(2'b10, 4'b1101, 5'b11110, 10'h155, 2'd0, 2'd1));
        check("rd1_cmd", {issued_valid, issued_cmd}, 5'b1_0011);
        check("cas_count_e1", count, 1);
        drive(4'd4, 1'b0, 2'd3, 2'd0, 14'd0, 10'h3C3, 1'b1);
        tick();
        in_valid = 1'b0;
        check("gap1_valid", issued_valid, 0);
        check("gap1_count", count, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("gap1_valid", issued_valid, 0);
            check("gap1_count", count, 2);
        end
        tick();
        check("rd2_pins", pins_vec(), exp_vec(2'b01, 4'b1101, 5'b11010, 10'h0AA, 2'd2, 2'd3));
        check("rd2_cmd", {issued_valid, issued_cmd}, 5'b1_0011);
        check("rd2_count", count, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("gap2_valid", issued_valid, 0);
            check("gap2_count", count, 1);
        end
        tick();
        check("wr_pins", pins_vec(), exp_vec(2'b10, 4'b1100, 5'b11110, 10'h3C3, 2'd3, 2'd0));
        check("wr_cmd", {issued_valid, issued_cmd}, 5'b1_0100);
        check("wr_count", count, 0);
        tick();
        check_des("wr_after");

        // Fill to DEPTH behind a blocked RD (tccd=11)
        repeat (8) tick();
        tccd = 4'd11;
        drive(4'd3, 1'b0, 2'd0, 2'd0, 14'd0, 10'd1, 1'b1);
        tick();
        drive(4'd3, 1'b0, 2'd0, 2'd0, 14'd0, 10'd2, 1'b1);
        tick();
        check("rda_cmd", {issued_valid, issued_cmd}, 5'b1_0011);
        check("rda_col", A9_A0, 1);
        check("fill_count", count, 1);
        for (int i = 1; i <= 7; i++) begin
            drive(4'd2, 1'b0, 2'd0, 2'd0, 14'(i), 10'd0, 1'b1);
            tick();
            check("fill_count", count, i + 1);
        end
        check("full_ready", in_ready, 0);
        drive(4'd11, 1'b1, 2'd0, 2'd0, 14'd0, 10'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_count", count, 8);
            check("full_ready", in_ready, 0);
            check("full_valid", issued_valid, 0);
        end
        tick();
        check("rdb_cmd", {issued_valid, issued_cmd}, 5'b1_0011);
        check("rdb_col", A9_A0, 2);
        check("rdb_count", count, 7);
        check("rdb_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("drain_cmd", {issued_valid, issued_cmd}, 5'b1_0010);
        check("drain_row", A9_A0, 1);
        check("ninth_count", count, 7);
        for (int i = 2; i <= 7; i++) begin
            tick();
            check("drain_cmd", {issued_valid, issued_cmd}, 5'b1_0010);
            check("drain_row", A9_A0, i);
            check("drain_count", count, 8 - i);
        end
        tick();
        check("zqcl_pins", pins_vec(), exp_vec(2'b01, 4'b1110, 5'h1F, 10'h3FF, 2'd3, 2'd3));
        check("zqcl_cmd", {issued_valid, issued_cmd}, 5'b1_1011);
        check("zqcl_count", count, 0);

        // Refresh held behind a blocked RD; two requests merge into one REF
        repeat (10) tick();
        tccd = 4'd6;
        drive(4'd3, 1'b0, 2'd0, 2'd0, 14'd0, 10'd5, 1'b1);
        tick();
        drive(4'd3, 1'b0, 2'd0, 2'd0, 14'd0, 10'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        check("rdc_cmd", {issued_valid, issued_cmd}, 5'b1_0011);
        ref_rank = 1'b1;
        ref_req  = 1'b1;
        tick();
        ref_req = 1'b0;
        check("refw_valid", issued_valid, 0);
        check("refw_ack", ref_ack, 0);
        tick();
        ref_req = 1'b1;
        check("refw_valid", issued_valid, 0);
        tick();
        ref_req = 1'b0;
        check("refw_valid", issued_valid, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("refw_valid", issued_valid, 0);
            check("refw_ack", ref_ack, 0);
        end
        tick();
        check("ref_pins", pins_vec(), exp_vec(2'b01, 4'b1001, 5'h1F, 10'h3FF, 2'd3, 2'd3));
        check("ref_cmd", {issued_valid, issued_cmd}, 5'b1_1001);
        check("ref_ack", ref_ack, 1);
        check("ref_count", count, 1);
        tick();
        check("rdd_cmd", {issued_valid, issued_cmd}, 5'b1_0011);
        check("rdd_col", A9_A0, 6);
        check("rdd_ack", ref_ack, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("noref_valid", issued_valid, 0);
            check("noref_ack", ref_ack, 0);
        end

        // tccd below 4 behaves as 4; illegal code issues as NOP
        repeat (8) tick();
        tccd = 4'd2;
        drive(4'd3, 1'b0, 2'd0, 2'd0, 14'd0, 10'd7, 1'b1);
        tick();
        drive(4'd3, 1'b0, 2'd0, 2'd0, 14'd0, 10'd8, 1'b1);
        tick();
        in_valid = 1'b0;
        check("min_rd1", {issued_valid, issued_cmd}, 5'b1_0011);
        check("min_rd1_col", A9_A0, 7);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("min_gap", issued_valid, 0);
        end
        tick();
        check("min_rd2", {issued_valid, issued_cmd}, 5'b1_0011);
        check("min_rd2_col", A9_A0, 8);
        drive(4'd13, 1'b1, 2'd0, 2'd1, 14'h0123, 10'h045, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("ill_pins", pins_vec(), exp_vec(2'b01, 4'hF, 5'h1F, 10'h3FF, 2'd3, 2'd3));
        check("ill_cmd", {issued_valid, issued_cmd}, 5'b1_0000);

        // Reset with five entries queued and a refresh pending
        repeat (8) tick();
        tccd = 4'd11;
        drive(4'd3, 1'b0, 2'd0, 2'd0, 14'd0, 10'd9, 1'b1);
        tick();
        drive(4'd3, 1'b0, 2'd0, 2'd0, 14'd0, 10'd10, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(4'd2, 1'b0, 2'd0, 2'd0, 14'(i), 10'd0, 1'b1);
            ref_req = (i == 3);
            tick();
        end
        in_valid = 1'b0;
        ref_req  = 1'b0;
        check("pre_rst_count", count, 5);
        reset = 1'b1;
        tick();
        check("mid_rst_count", count, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_ack", ref_ack, 0);
        check_des("mid_rst");
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_rst_valid", issued_valid, 0);
            check("post_rst_count", count, 0);
            check("post_rst_ack", ref_ack, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
